// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - round-robin LTC2308 scan controller with per-channel result register file
// Optional ADC_SCAN_AVG_EN: publish the mean of every 4 conversions per channel.
module adc_scan_ctrl #(
    parameter int NUM_CH      = 8,
    parameter int SCK_HALF    = 2,
    parameter int CONV_CYCLES = 80,
    parameter int RES_W       = 12
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             enable,
    output logic             adc_convst,
    output logic             adc_sck,
    output logic             adc_sdi,
    input  logic             adc_sdo,
    input  logic [2:0]       rd_chan,
    output logic [RES_W-1:0] rd_result,
    output logic             rd_valid,
    output logic             sample_valid,
    output logic [2:0]       sample_chan,
    output logic [RES_W-1:0] sample_data,
    output logic             busy
);

    localparam int CONV_LAST = CONV_CYCLES + 1;
    localparam int CNT_MAX   = (CONV_LAST > SCK_HALF) ? CONV_LAST : SCK_HALF;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CONV_END   = CNT_W'(CONV_LAST);
    localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(SCK_HALF - 1);
    localparam logic [CNT_W-1:0] CONVST_LEN = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);
    localparam logic [3:0]       NUM_CH_L   = 4'(NUM_CH);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       half_q, half_d;
    logic [11:0]      shift_q, shift_d;
    logic [2:0]       cfg_chan_q, cfg_chan_d;
    logic [2:0]       prev_chan_q, prev_chan_d;
    logic             prime_q, prime_d;
    logic             convst_q, convst_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic [RES_W-1:0] regfile_q [0:7];
    logic [RES_W-1:0] regfile_d [0:7];
    logic [7:0]       valid_q, valid_d;
    logic             publish;
    logic [RES_W-1:0] pub_data;
    logic [11:0]      cfg_word;
    logic             rd_ok;
`ifdef ADC_SCAN_AVG_EN
    logic [13:0]      acc_q  [0:7];
    logic [13:0]      acc_d  [0:7];
    logic [1:0]       acnt_q [0:7];
    logic [1:0]       acnt_d [0:7];
    logic [13:0]      acc_sum;
`endif

    // S/D, O/S, S1, S0, UNI, SLP followed by six zero bits
    assign cfg_word = {1'b1, cfg_chan_q[0], cfg_chan_q[2], cfg_chan_q[1], 1'b1, 1'b0, 6'b0};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        shift_d     = shift_q;
        cfg_chan_d  = cfg_chan_q;
        prev_chan_d = prev_chan_q;
        prime_d     = prime_q;
        regfile_d   = regfile_q;
        valid_d     = valid_q;
        publish     = 1'b0;
        pub_data    = '0;
`ifdef ADC_SCAN_AVG_EN
        acc_d   = acc_q;
        acnt_d  = acnt_q;
        acc_sum = acc_q[prev_chan_q] + {2'b00, shift_q};
`endif
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (cnt_q == CONV_END) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    // end of a low half-period is an SCK rising edge
                    if (!half_q[0]) shift_d = {shift_q[10:0], adc_sdo};
                    if (half_q == 5'd23) state_d = DONE;
                    else half_d = half_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                prev_chan_d = cfg_chan_q;
                cfg_chan_d  = (cfg_chan_q == LAST_CH) ? 3'd0 : cfg_chan_q + 3'd1;
                prime_d     = 1'b1;
                if (prime_q) begin
`ifdef ADC_SCAN_AVG_EN
                    if (acnt_q[prev_chan_q] == 2'd3) begin
                        publish              = 1'b1;
                        pub_data             = RES_W'(acc_sum[13:2]);
                        acc_d[prev_chan_q]   = '0;
                        acnt_d[prev_chan_q]  = '0;
                    end else begin
                        acc_d[prev_chan_q]  = acc_sum;
                        acnt_d[prev_chan_q] = acnt_q[prev_chan_q] + 2'd1;
                    end
`else
                    publish  = 1'b1;
                    pub_data = RES_W'(shift_q);
`endif
                end
                if (publish) begin
                    regfile_d[prev_chan_q] = pub_data;
                    valid_d[prev_chan_q]   = 1'b1;
                end
                if (enable) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    prime_d = 1'b0;
`ifdef ADC_SCAN_AVG_EN
                    for (int i = 0; i < 8; i++) begin
                        acc_d[i]  = '0;
                        acnt_d[i] = '0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // pins are registered from the next-state view so they align with the state register
        convst_d = (state_d == CONV) && (cnt_d < CONVST_LEN);
        sck_d    = (state_d == SHIFT) && half_d[0];
        sdi_d    = (state_d == SHIFT) ? cfg_word[4'd11 - half_d[4:1]] : 1'b0;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_q      <= '0;
            shift_q     <= '0;
            cfg_chan_q  <= '0;
            prev_chan_q <= '0;
            prime_q     <= 1'b0;
            convst_q    <= 1'b0;
            sck_q       <= 1'b0;
            sdi_q       <= 1'b0;
            valid_q     <= '0;
            for (int i = 0; i < 8; i++) begin
                regfile_q[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
                acc_q[i]     <= '0;
                acnt_q[i]    <= '0;
`endif
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            shift_q     <= shift_d;
            cfg_chan_q  <= cfg_chan_d;
            prev_chan_q <= prev_chan_d;
            prime_q     <= prime_d;
            convst_q    <= convst_d;
            sck_q       <= sck_d;
            sdi_q       <= sdi_d;
            valid_q     <= valid_d;
            for (int i = 0; i < 8; i++) begin
                regfile_q[i] <= regfile_d[i];
`ifdef ADC_SCAN_AVG_EN
                acc_q[i]     <= acc_d[i];
                acnt_q[i]    <= acnt_d[i];
`endif
            end
        end
    end

    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;
    assign busy         = (state_q != IDLE);
    assign sample_valid = publish;
    assign sample_chan  = publish ? prev_chan_q : 3'd0;
    assign sample_data  = pub_data;
    assign rd_ok        = ({1'b0, rd_chan} < NUM_CH_L);
    assign rd_result    = rd_ok ? regfile_q[rd_chan] : '0;
    assign rd_valid     = rd_ok & valid_q[rd_chan];

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - self-checking bench for adc_scan_ctrl with an LTC2308 pin model
module tb_adc_scan_ctrl;
    localparam int NUM_CH      = 4;
    localparam int SCK_HALF    = 2;
    localparam int CONV_CYCLES = 80;
    localparam int RES_W       = 12;
    localparam int FRAME       = 2 + CONV_CYCLES + 24 * SCK_HALF + 1;
    localparam int FIRST_SCK   = 2 + CONV_CYCLES + SCK_HALF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             adc_convst, adc_sck, adc_sdi;
    logic             adc_sdo = 1'b0;
    logic [2:0]       rd_chan = 3'd0;
    logic [RES_W-1:0] rd_result;
    logic             rd_valid;
    logic             sample_valid;
    logic [2:0]       sample_chan;
    logic [RES_W-1:0] sample_data;
    logic             busy;

    always #5 clk = ~clk;

    adc_scan_ctrl #(
        .NUM_CH(NUM_CH), .SCK_HALF(SCK_HALF), .CONV_CYCLES(CONV_CYCLES), .RES_W(RES_W)
    ) dut (
        .clk_clk(clk), .reset_reset(rst), .enable(enable),
        .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
        .rd_chan(rd_chan), .rd_result(rd_result), .rd_valid(rd_valid),
        .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
        .busy(busy)
    );

    // ADC model: result latched at CONVST for the channel configured in the previous frame
    logic [11:0] mdl_res = 12'h000;
    int          mdl_bit = 0;
    logic [2:0]  mdl_chan = 3'd5;
    logic [11:0] sdi_sr = 12'h000;
    int          sdi_n = 0;
    logic [11:0] cfg_log [$];
    int          avg_k = 0;

    function automatic logic [11:0] avg_val(input int k);
        case (k)
            0: return 12'd100;
            1: return 12'd101;
            2: return 12'd102;
            default: return 12'd104;
        endcase
    endfunction

    always @(posedge adc_convst or negedge adc_sck) begin
        if (adc_convst) begin
            mdl_res = {mdl_chan, 9'h0A5};
`ifdef ADC_SCAN_AVG_EN
            if (mdl_chan == 3'd0 && avg_k < 4) begin
                mdl_res = avg_val(avg_k);
                avg_k++;
            end
`endif
            mdl_bit = 0;
            adc_sdo = mdl_res[11];
        end else begin
            mdl_bit++;
            adc_sdo = (mdl_bit < 12) ? mdl_res[11 - mdl_bit] : 1'b0;
        end
    end

    always @(posedge adc_sck or posedge rst) begin
        if (rst) begin
            sdi_n    = 0;
            mdl_chan = 3'd5;
        end else begin
            sdi_sr = {sdi_sr[10:0], adc_sdi};
            sdi_n++;
            if (sdi_n == 12) begin
                cfg_log.push_back(sdi_sr);
                mdl_chan = {sdi_sr[9], sdi_sr[8], sdi_sr[10]};
                sdi_n    = 0;
            end
        end
    end

    typedef struct {
        logic [2:0]  chan;
        logic [11:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]  chan;
        logic        valid;
        logic [11:0] result;
    } rd_vec_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   strobes = 0;
    int   conv_seen = 0;
    int   conv_rise_cyc = 0;
    int   convst_run = 0;
    logic convst_prev = 1'b0;
    logic sck_prev = 1'b0;
    logic first_sck_pending = 1'b0;
    logic interval_chk = 1'b0;
    int   last_strobe_cyc = -1;
    int   first_strobe_cyc = -1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [2:0] c, input logic [11:0] d);
        exp_t e;
        e.chan = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (adc_convst && !convst_prev) begin
            conv_rise_cyc     = cyc;
            conv_seen++;
            first_sck_pending = 1'b1;
        end
        if (!adc_convst && convst_prev) check("convst_width", convst_run, 2);
        convst_run = adc_convst ? convst_run + 1 : 0;
        if (adc_sck && !sck_prev && first_sck_pending) begin
            first_sck_pending = 1'b0;
            check("first_sck_offset", cyc - conv_rise_cyc, FIRST_SCK);
        end
        if (sample_valid) begin
            strobes++;
            if (interval_chk) begin
                if (last_strobe_cyc < 0) first_strobe_cyc = cyc;
                else check("strobe_interval", cyc - last_strobe_cyc, FRAME);
            end
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual chan=%0d data=%0h required=none", sample_chan, sample_data);
            end else begin
                e = exp_q.pop_front();
                check("strobe_chan", sample_chan, e.chan);
                check("strobe_data", sample_data, e.data);
            end
        end
        convst_prev = adc_convst;
        sck_prev    = adc_sck;
    endtask

    task automatic wait_conv(input int budget);
        int start = conv_seen;
        int n = 0;
        while (conv_seen == start && n < budget) begin
            tick();
            n++;
        end
        check("conv_timeout", (conv_seen != start) ? 1 : 0, 1);
    endtask

    task automatic wait_strobes_to(input int target, input int budget);
        int n = 0;
        while (strobes < target && n < budget) begin
            tick();
            n++;
        end
        check("strobe_timeout", strobes, target);
    endtask

    initial begin
        rd_vec_t    rd_tab [8];
        logic [11:0] cfg_exp [4];
        int         conv0;
        int         s0;

        rd_tab[0] = '{3'd0, 1'b1, 12'h0A5};
        rd_tab[1] = '{3'd1, 1'b1, 12'h2A5};
        rd_tab[2] = '{3'd2, 1'b1, 12'h4A5};
        rd_tab[3] = '{3'd3, 1'b1, 12'h6A5};
        rd_tab[4] = '{3'd4, 1'b0, 12'h000};
        rd_tab[5] = '{3'd5, 1'b0, 12'h000};
        rd_tab[6] = '{3'd6, 1'b0, 12'h000};
        rd_tab[7] = '{3'd7, 1'b0, 12'h000};
        cfg_exp[0] = 12'b100010_000000;
        cfg_exp[1] = 12'b110010_000000;
        cfg_exp[2] = 12'b100110_000000;
        cfg_exp[3] = 12'b110110_000000;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_convst", adc_convst, 0);
        check("rst_sck", adc_sck, 0);
        check("rst_sdi", adc_sdi, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_chan", sample_chan, 0);
        check("rst_sample_data", sample_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_result", rd_result, 0);
        rst = 1'b0;
        tick();

`ifndef ADC_SCAN_AVG_EN
        // continuous scan: first frame discarded, then 0,1,2,3,0
        push_exp(3'd0, 12'h0A5);
        push_exp(3'd1, 12'h2A5);
        push_exp(3'd2, 12'h4A5);
        push_exp(3'd3, 12'h6A5);
        push_exp(3'd0, 12'h0A5);
        interval_chk    = 1'b1;
        last_strobe_cyc = -1;
        enable = 1'b1;
        wait_conv(10);
        conv0 = conv_rise_cyc;
        wait_strobes_to(strobes + 5, 1000);
        check("first_strobe_latency", first_strobe_cyc - conv0, 2 * FRAME - 1);
        interval_chk = 1'b0;
        check("cfg_log_size", (cfg_log.size() >= 4) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++)
            if (i < cfg_log.size()) check("sdi_cfg_word", cfg_log[i], cfg_exp[i]);

        for (int i = 0; i < 8; i++) begin
            rd_chan = rd_tab[i].chan;
            #1;
            check("rd_valid", rd_valid, rd_tab[i].valid);
            check("rd_result", rd_result, rd_tab[i].result);
        end

        // enable dropped mid-SHIFT of frame 3
        enable = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        push_exp(3'd0, 12'h0A5);
        push_exp(3'd1, 12'h2A5);
        s0 = strobes;
        enable = 1'b1;
        wait_conv(10);
        wait_conv(200);
        wait_conv(200);
        repeat (100) tick();
        enable = 1'b0;
        wait_strobes_to(s0 + 2, 200);
        tick();
        check("drop_busy", busy, 0);
        check("drop_convst", adc_convst, 0);
        check("drop_sck", adc_sck, 0);
        check("drop_sdi", adc_sdi, 0);
        repeat (20) tick();
        check("drop_no_extra", exp_q.size(), 0);

        // re-enable: prime frame discarded again
        push_exp(3'd3, 12'h6A5);
        push_exp(3'd0, 12'h0A5);
        s0 = strobes;
        enable = 1'b1;
        wait_conv(10);
        conv0 = conv_rise_cyc;
        wait_strobes_to(s0 + 1, 400);
        check("reenable_latency", last_strobe_cyc - conv0, 2 * FRAME - 1);
        repeat (10) tick();
        enable = 1'b0;
        wait_strobes_to(s0 + 2, 200);
        tick();
        check("reenable_idle_busy", busy, 0);
`else
        // ch0 conversions 100,101,102,104 -> one strobe of 101
        push_exp(3'd0, 12'd101);
        push_exp(3'd1, 12'h2A5);
        interval_chk    = 1'b1;
        last_strobe_cyc = -1;
        s0 = strobes;
        enable = 1'b1;
        wait_conv(10);
        conv0 = conv_rise_cyc;
        wait_strobes_to(s0 + 2, 2200);
        enable = 1'b0;
        interval_chk = 1'b0;
        check("avg_first_strobe", first_strobe_cyc - conv0, 14 * FRAME - 1);
        rd_chan = 3'd0;
        #1;
        check("avg_rd_result0", rd_result, 101);
        check("avg_rd_valid0", rd_valid, 1);
        rd_chan = 3'd2;
        #1;
        check("avg_rd_valid2", rd_valid, 0);
        tick();
        tick();
        check("avg_idle_busy", busy, 0);
`endif

        // reset asserted mid-SHIFT
        enable = 1'b1;
        wait_conv(10);
        repeat (90) tick();
        check("pre_reset_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sck", adc_sck, 0);
        check("arst_sdi", adc_sdi, 0);
        check("arst_convst", adc_convst, 0);
        check("arst_sample_valid", sample_valid, 0);
        check("arst_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            rd_chan = 3'(i);
            #1;
            check("arst_rd_valid", rd_valid, 0);
        end
        enable = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
